// File: rtl/uart_rx_ctrl.sv
// Sequencing controller between a uart_rx receiver and a byte consumer: unloads
// completed bytes into a local FIFO, streams them out and flags inter-byte idle.
module uart_rx_ctrl #(
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 160
) (
    input  logic                         rxclk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         flush,
    output logic                         rx_enable,
    output logic                         uld_rx_data,
    input  logic                         rx_empty,
    input  logic [7:0]                   rx_data,
    output logic [7:0]                   m_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         rx_timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [15:0]   TO_MAX  = 16'(TIMEOUT_CYC);
    localparam logic [15:0]   TO_LAST = 16'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        UNLOAD,
        CAPTURE
    } state_t;

    state_t         state;
    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [15:0]    to_cnt;
    logic           push;
    logic           pop;
    logic           room;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v < TO_MAX) ? v + 16'd1 : v;
    endfunction

    assign push    = (state == CAPTURE) && !flush;
    assign pop     = m_valid && m_ready;
    assign room    = (fifo_count < DEPTH_C);
    assign m_valid = (fifo_count != '0);
    assign m_data  = mem[rd_ptr];

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            rx_enable <= 1'b0;
        end else begin
            rx_enable <= enable;
        end
    end

    // The full check in IDLE stays valid: nothing else can push before CAPTURE.
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            uld_rx_data <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rx_empty && room) begin
                        state       <= UNLOAD;
                        uld_rx_data <= 1'b1;
                    end else begin
                        uld_rx_data <= 1'b0;
                    end
                end
                UNLOAD: begin
                    state       <= CAPTURE;
                    uld_rx_data <= 1'b0;
                end
                CAPTURE: begin
                    state       <= IDLE;
                    uld_rx_data <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    uld_rx_data <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge rxclk) begin
        if (push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    // Counter saturates so the pulse fires once per push.
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (push || flush || (fifo_count == '0)) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= sat_inc(to_cnt);
        end
    end

    assign rx_timeout = m_valid && !push && !flush && (to_cnt == TO_LAST);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: timing table, directed corner sequences
// and randomized traffic checked against a queue-based reference model.
module tb_uart_rx_ctrl;

    localparam int DEPTH = 8;
    localparam int TO    = 160;

    logic       rxclk;
    logic       reset;
    logic       enable;
    logic       flush;
    logic       rx_enable;
    logic       uld_rx_data;
    logic       rx_empty;
    logic [7:0] rx_data;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [3:0] fifo_count;
    logic       rx_timeout;

    uart_rx_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
        .rxclk(rxclk),
        .reset(reset),
        .enable(enable),
        .flush(flush),
        .rx_enable(rx_enable),
        .uld_rx_data(uld_rx_data),
        .rx_empty(rx_empty),
        .rx_data(rx_data),
        .m_data(m_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .fifo_count(fifo_count),
        .rx_timeout(rx_timeout)
    );

    initial begin
        rxclk = 1'b0;
        forever #5 rxclk = ~rxclk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    int total = 0;
    int bad   = 0;

    // Reference model: FIFO contents as a queue, unload handshake phase,
    // idle cycle count since last push, and a behavioural receiver.
    logic [7:0] q[$];
    logic [7:0] popped[$];
    int         m_ph;
    int         m_idle;
    logic       m_rxen;
    logic       rcv_full;
    logic [7:0] rcv_hold;
    logic [7:0] rcv_data;
    int         cyc;

    logic       obs_uld;
    logic       obs_to;
    logic       obs_valid;
    logic [3:0] obs_cnt;
    logic [7:0] obs_data;
    int         obs_cyc;

    typedef struct {
        logic       en;
        logic       rxe;
        logic       rdy;
        logic [7:0] rxd;
        logic       exp_rxen;
        logic       exp_uld;
        logic       exp_mv;
        logic [7:0] exp_data;
        logic [3:0] exp_cnt;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model.
    task automatic step(input logic en, input logic fl, input logic rdy,
                        input logic arrive, input logic [7:0] nb);
        int   sz;
        logic push_m;
        logic pop_m;
        logic start_m;
        logic exp_to;
        enable   = en;
        flush    = fl;
        m_ready  = rdy;
        rx_empty = !rcv_full;
        rx_data  = rcv_data;
        #1;
        sz     = q.size();
        push_m = (m_ph == 2) && !fl;
        pop_m  = (sz != 0) && rdy;
        exp_to = (sz != 0) && !push_m && !fl && (m_idle == TO - 1);
        check("rx_enable", rx_enable, m_rxen);
        check("uld_rx_data", uld_rx_data, (m_ph == 1));
        check("m_valid", m_valid, (sz != 0));
        check("fifo_count", fifo_count, sz);
        if (sz != 0) check("m_data", m_data, q[0]);
        check("rx_timeout", rx_timeout, exp_to);
        obs_uld   = uld_rx_data;
        obs_to    = rx_timeout;
        obs_valid = m_valid;
        obs_cnt   = fifo_count;
        obs_data  = m_data;
        obs_cyc   = cyc;
        if (m_valid && rdy) popped.push_back(m_data);
        start_m = (m_ph == 0) && rcv_full && (sz < DEPTH);
        if (fl) begin
            q.delete();
        end else begin
            if (pop_m) void'(q.pop_front());
            if (push_m) q.push_back(rcv_data);
        end
        if (push_m || fl || sz == 0) m_idle = 0;
        else if (m_idle < TO) m_idle = m_idle + 1;
        if (m_ph == 1) begin
            rcv_data = rcv_hold;
            rcv_full = 1'b0;
        end else if (arrive && !rcv_full) begin
            rcv_hold = nb;
            rcv_full = 1'b1;
        end
        m_ph   = (m_ph == 0) ? (start_m ? 1 : 0) : ((m_ph == 1) ? 2 : 0);
        m_rxen = en;
        cyc++;
        @(posedge rxclk);
        #1;
    endtask

    task automatic load_byte(input logic [7:0] b, input logic rdy);
        step(1'b1, 1'b0, rdy, 1'b1, b);
        repeat (3) step(1'b1, 1'b0, rdy, 1'b0, 8'h00);
    endtask

    initial begin
        int         t_obs;
        int         pc;
        int         pulses;
        int         maxcnt;
        int         rdy_pct;
        logic       found;
        logic [7:0] exp_bytes[$];

        reset    = 1'b1;
        enable   = 1'b0;
        flush    = 1'b0;
        m_ready  = 1'b0;
        rx_empty = 1'b1;
        rx_data  = 8'h00;
        cyc      = 0;

        //               en  rxe rdy rxd    rxen uld mv  data   cnt
        tbl[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 4'd1};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 4'd1};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0};

        repeat (2) @(posedge rxclk);
        #1;
        check("reset_rx_enable", rx_enable, 0);
        check("reset_uld", uld_rx_data, 0);
        check("reset_m_valid", m_valid, 0);
        check("reset_fifo_count", fifo_count, 0);
        check("reset_rx_timeout", rx_timeout, 0);
        reset = 1'b0;

        // Basic unload timing.
        for (int i = 0; i < 8; i++) begin
            enable   = tbl[i].en;
            rx_empty = tbl[i].rxe;
            m_ready  = tbl[i].rdy;
            rx_data  = tbl[i].rxd;
            #1;
            check($sformatf("tbl%0d_rx_enable", i), rx_enable, tbl[i].exp_rxen);
            check($sformatf("tbl%0d_uld", i), uld_rx_data, tbl[i].exp_uld);
            check($sformatf("tbl%0d_m_valid", i), m_valid, tbl[i].exp_mv);
            check($sformatf("tbl%0d_fifo_count", i), fifo_count, tbl[i].exp_cnt);
            if (tbl[i].exp_mv) check($sformatf("tbl%0d_m_data", i), m_data, tbl[i].exp_data);
            @(posedge rxclk);
            #1;
        end

        q.delete();
        m_ph     = 0;
        m_idle   = 0;
        m_rxen   = 1'b1;
        rcv_full = 1'b0;
        rcv_hold = 8'h00;
        rcv_data = 8'hA5;

        // Fill to full, hold a ninth byte in the receiver, release one slot.
        popped.delete();
        for (int b = 1; b <= 8; b++) load_byte(8'(b), 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h09);
        repeat (6) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            check("full_no_uld", obs_uld, 0);
        end
        check("full_count", obs_cnt, 8);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        check("first_pop_count", popped.size(), 1);
        if (popped.size() > 0) check("first_pop_data", popped[0], 8'h01);
        found = 1'b0;
        repeat (4) if (!found) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            if (obs_uld) found = 1'b1;
        end
        check("resume_uld", found, 1);
        popped.delete();
        repeat (14) step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        check("drain_size", popped.size(), 8);
        for (int i = 0; i < 8 && i < popped.size(); i++)
            check($sformatf("drain_order%0d", i), popped[i], 8'(i + 2));

        // Sustained streaming across pointer wrap.
        popped.delete();
        exp_bytes.delete();
        maxcnt = 0;
        for (int n = 0; n < 20; n++) begin
            exp_bytes.push_back(8'($urandom));
            step(1'b1, 1'b0, 1'b1, 1'b1, exp_bytes[n]);
            repeat (159) begin
                step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
                if (int'(obs_cnt) > maxcnt) maxcnt = int'(obs_cnt);
            end
        end
        check("stream_size", popped.size(), 20);
        for (int i = 0; i < 20 && i < popped.size(); i++)
            check($sformatf("stream_order%0d", i), popped[i], exp_bytes[i]);
        check("stream_max_count", (maxcnt <= 1), 1);

        // Idle timeout: one pulse per push, 160 cycles after the push cycle.
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h5A);
        t_obs = -1; pc = -1; pulses = 0;
        repeat (400) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            if (t_obs < 0 && obs_cnt == 4'd1) t_obs = obs_cyc;
            if (obs_to) begin pulses++; pc = obs_cyc; end
        end
        check("to1_pulses", pulses, 1);
        check("to1_delay", pc - t_obs, 159);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h6B);
        t_obs = -1; pc = -1; pulses = 0;
        repeat (400) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            if (t_obs < 0 && obs_cnt == 4'd2) t_obs = obs_cyc;
            if (obs_to) begin pulses++; pc = obs_cyc; end
        end
        check("to2_pulses", pulses, 1);
        check("to2_delay", pc - t_obs, 159);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);

        // Flush in the CAPTURE cycle of a fourth byte.
        for (int b = 0; b < 3; b++) load_byte(8'(8'h30 + b), 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'hEE);
        found = 1'b0;
        repeat (10) if (!found) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            if (obs_uld) found = 1'b1;
        end
        check("flush_uld_seen", found, 1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check("flush_count", obs_cnt, 0);
        check("flush_valid", obs_valid, 0);
        pulses = 0;
        repeat (200) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            if (obs_to) pulses++;
        end
        check("flush_no_timeout", pulses, 0);

        // Asynchronous reset while an unload pulse is high.
        load_byte(8'h11, 1'b0);
        load_byte(8'h22, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h3C);
        found = 1'b0;
        repeat (6) if (!found) begin
            if (m_ph == 1) found = 1'b1;
            else step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        end
        check("rst_uld_reached", found, 1);
        if (found) begin
            check("rst_pre_uld", uld_rx_data, 1);
            reset = 1'b1;
            #1;
            check("rst_uld", uld_rx_data, 0);
            check("rst_m_valid", m_valid, 0);
            check("rst_fifo_count", fifo_count, 0);
            check("rst_rx_enable", rx_enable, 0);
            q.delete();
            m_ph   = 0;
            m_idle = 0;
            m_rxen = 1'b0;
            @(posedge rxclk);
            #1;
            reset = 1'b0;
            found = 1'b0;
            repeat (10) if (!found) begin
                step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
                if (obs_valid) found = 1'b1;
            end
            check("rst_resume_valid", found, 1);
            check("rst_resume_data", obs_data, 8'h3C);
        end

        // Randomized traffic against the model.
        rdy_pct = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) rdy_pct = $urandom_range(0, 100);
            step(1'($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 96) == 0),
                 1'($urandom_range(0, 99) < rdy_pct),
                 1'($urandom_range(0, 3) == 0),
                 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
